// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int CNT_WIDTH   = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM, 32-bit words, per-byte write enable, registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // NOTE: the storage array has no reset branch; its contents are undefined
    // until written, and a reset would force it out of RAM macros into flops.
    always_ff @(posedge clk) begin
        if (en && we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store, commits it after LATENCY
// cycles and answers with a single-cycle valid strobe.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        valid
);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be within 1..4");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_INIT =
        CNT_WIDTH'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  cap_we;
    logic [3:0]            cap_mask;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [31:0]           cap_data;

    logic                  accept;
    logic                  commit;
    logic                  use_live;
    logic                  arr_we;
    logic [3:0]            arr_be;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [31:0]           arr_wdata;
    logic                  unused_addr_bits;

    assign accept = (state == IDLE) && request;
    assign commit = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == '0));

    // With LATENCY=1 acceptance and commit share an edge, so the RAM must see
    // the live request rather than the not-yet-loaded capture registers.
    assign use_live  = (state == IDLE);
    assign arr_we    = use_live ? we_re                       : cap_we;
    assign arr_be    = use_live ? mask                        : cap_mask;
    assign arr_addr  = use_live ? address[ADDR_WIDTH+1:2]     : cap_idx;
    assign arr_wdata = use_live ? store_data                  : cap_data;

    assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            valid    <= 1'b0;
            cap_we   <= 1'b0;
            cap_mask <= '0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        cap_we   <= we_re;
                        cap_mask <= mask;
                        cap_idx  <= address[ADDR_WIDTH+1:2];
                        cap_data <= store_data;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (load_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=1 and one LATENCY=3 instance
// share the data inputs; each has its own request line.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        request1, request3;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address, store_data;
    logic [31:0] ld1, ld3;
    logic        v1, v3;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .request(request1), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data), .load_data(ld1), .valid(v1)
    );

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .request(request3), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data), .load_data(ld3), .valid(v3)
    );

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          sel;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_v(input int sel);
        return (sel == 1) ? v1 : v3;
    endfunction

    function automatic logic [31:0] get_ld(input int sel);
        return (sel == 1) ? ld1 : ld3;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 1) ? 1 : 3;
    endfunction

    task automatic set_req(input int sel, input logic val);
        if (sel == 1) request1 = val;
        else          request3 = val;
    endtask

    // Scoreboard: every valid pulse retires the oldest expected response.
    always @(negedge clk) begin
        if (v1 || v3) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {30'b0, v3, v1}, 32'd0);
            end else begin
                head = sb.pop_front();
                check("valid_source", {30'b0, v3, v1}, (head.sel == 1) ? 32'd1 : 32'd2);
                if (head.is_load) check("load_data", get_ld(head.sel), head.data);
            end
        end
    end

    task automatic drive(input int sel, input bit we, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        we_re = we; mask = m; address = a; store_data = d;
        set_req(sel, 1'b1);
        e.is_load = !we; e.data = exp; e.sel = sel;
        sb.push_back(e);
    endtask

    // Waits (bounded) for the next valid on the chosen instance; returns negedges waited.
    task automatic wait_valid(input int sel, input bit toggle, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!get_v(sel) && toggle) begin
                address    = $urandom;
                store_data = $urandom;
                mask       = 4'($urandom);
            end
        end while (!get_v(sel) && n < 12);
    endtask

    task automatic txn(input int sel, input bit we, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input bit toggle);
        int n;
        @(negedge clk);
        drive(sel, we, m, a, d, exp);
        @(posedge clk);
        wait_valid(sel, toggle, n);
        check("latency", n, lat_of(sel));
        if (n >= 12) sb.delete();
        set_req(sel, 1'b0);
        @(negedge clk);
        check("valid_width", {31'b0, get_v(sel)}, 32'd0);
    endtask

    // Store of all-ones with reset asserted on its commit edge.
    task automatic rst_txn(input int sel, input logic [31:0] a);
        @(negedge clk);
        we_re = 1'b1; mask = 4'hF; address = a; store_data = 32'hFFFF_FFFF;
        set_req(sel, 1'b1);
        for (int k = 0; k < lat_of(sel) - 1; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_req(sel, 1'b0);
        check("rst_valid", {31'b0, get_v(sel)}, 32'd0);
        check("rst_load_data", get_ld(sel), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    // Load then store with request held high throughout.
    task automatic b2b(input int sel, input logic [31:0] la, input logic [31:0] lexp,
                       input logic [31:0] sa, input logic [31:0] sd);
        int n;
        @(negedge clk);
        drive(sel, 1'b0, 4'h0, la, 32'h0, lexp);
        @(posedge clk);
        wait_valid(sel, 1'b0, n);
        check("b2b_first_latency", n, lat_of(sel));
        drive(sel, 1'b1, 4'hF, sa, sd, 32'h0);
        wait_valid(sel, 1'b0, n);
        check("b2b_spacing", n, lat_of(sel) + 1);
        if (n >= 12) sb.delete();
        set_req(sel, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; request1 = 1'b0; request3 = 1'b0;
        we_re = 1'b0; mask = 4'h0; address = 32'h0; store_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_valid", {30'b0, v3, v1}, 32'd0);
        check("reset_ld1", ld1, 32'd0);
        check("reset_ld3", ld3, 32'd0);

        // LATENCY = 1
        txn(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        txn(1, 0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        txn(1, 1, 4'hF, 32'h10, 32'h1122_3344, 32'h0, 0);
        txn(1, 1, 4'h8, 32'h13, 32'hAA00_0000, 32'h0, 0);
        txn(1, 0, 4'h5, 32'h10, 32'h0, 32'hAA22_3344, 0);
        txn(1, 1, 4'hF, 32'h20, 32'h5555_5555, 32'h0, 0);
        txn(1, 1, 4'h0, 32'h20, 32'h1234_5678, 32'h0, 0);
        txn(1, 0, 4'h0, 32'h20, 32'h0, 32'h5555_5555, 0);
        txn(1, 1, 4'hF, 32'h30, 32'h0, 32'h0, 0);
        rst_txn(1, 32'h30);
        txn(1, 0, 4'h0, 32'h30, 32'h0, 32'h0, 0);
        txn(1, 1, 4'hF, 32'h400, 32'hCAFE_F00D, 32'h0, 0);
        txn(1, 0, 4'h0, 32'h000, 32'h0, 32'hCAFE_F00D, 0);
        b2b(1, 32'h20, 32'h5555_5555, 32'h40, 32'hA5A5_A5A5);
        txn(1, 0, 4'h0, 32'h41, 32'h0, 32'hA5A5_A5A5, 0);

        // LATENCY = 3
        txn(3, 1, 4'hF, 32'h10, 32'h0BAD_F00D, 32'h0, 0);
        txn(3, 0, 4'h0, 32'h10, 32'h0, 32'h0BAD_F00D, 1);
        txn(3, 1, 4'hF, 32'h14, 32'h1357_9BDF, 32'h0, 1);
        txn(3, 0, 4'h0, 32'h14, 32'h0, 32'h1357_9BDF, 0);
        txn(3, 1, 4'h3, 32'h14, 32'hFFFF_0000, 32'h0, 0);
        txn(3, 0, 4'h0, 32'h14, 32'h0, 32'h1357_0000, 0);
        txn(3, 1, 4'hF, 32'h50, 32'h0, 32'h0, 0);
        rst_txn(3, 32'h50);
        txn(3, 0, 4'h0, 32'h50, 32'h0, 32'h0, 0);
        txn(3, 1, 4'hF, 32'h7FC, 32'h600D_CAFE, 32'h0, 0);
        txn(3, 0, 4'h0, 32'h3FC, 32'h0, 32'h600D_CAFE, 0);
        b2b(3, 32'h10, 32'h0BAD_F00D, 32'h60, 32'h8765_4321);
        txn(3, 0, 4'h0, 32'h60, 32'h0, 32'h8765_4321, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
